grf_wr_arbiter: RTL and testbench

Shares the single general-register-file write port between two writeback requesters: ch0 is the pipeline W stage and ch1 is a multi-cycle result source such as the MDU or a late load. Each channel has a valid/ready handshake and a one-entry buffer. A round-robin grant moves one buffered write per cycle into registered outputs that drive the GRF write port (write_enable, write_address, write_data, PC). A pending-write bitmap tells the hazard logic which registers still have writes in flight.

---
 rtl/grf_arb_pkg.sv | 21 ++
 rtl/grf_wr_arbiter_if.sv | 27 ++
 rtl/grf_arb_slot.sv | 33 +++
 rtl/grf_wr_arbiter.sv | 80 ++++++++
 tb/tb_grf_wr_arbiter.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/grf_arb_pkg.sv
// Shared parameters and the buffered write record for the GRF write-port arbiter.
package grf_arb_pkg;

    localparam int N_REQ = 2;
    localparam int AW    = 5;
    localparam int DW    = 32;

    localparam logic [AW-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [DW-1:0] pc;
    } wr_entry_t;

    // Writes to the hard-wired zero register are accepted but never reach the GRF.
    function automatic logic is_reg_zero(input logic [AW-1:0] addr);
        return addr == REG_ZERO;
    endfunction

endpackage

// File: rtl/grf_wr_arbiter_if.sv
// Requester handshakes and GRF write-port signals of the writeback arbiter.
interface grf_wr_arbiter_if;
    import grf_arb_pkg::*;

    logic [N_REQ-1:0]         req_valid;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ-1:0][AW-1:0] req_addr;
    logic [N_REQ-1:0][DW-1:0] req_data;
    logic [N_REQ-1:0][DW-1:0] req_pc;

    logic                     grf_we;
    logic [AW-1:0]            grf_waddr;
    logic [DW-1:0]            grf_wdata;
    logic [DW-1:0]            grf_pc;
    logic [31:0]              pending;

    modport master (
        output req_valid, req_addr, req_data, req_pc,
        input  req_ready, grf_we, grf_waddr, grf_wdata, grf_pc, pending
    );

    modport slave (
        input  req_valid, req_addr, req_data, req_pc,
        output req_ready, grf_we, grf_waddr, grf_wdata, grf_pc, pending
    );

endinterface

// File: rtl/grf_arb_slot.sv
// One-entry writeback buffer for a single requester channel.
module grf_arb_slot
    import grf_arb_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      in_valid,
    input  wr_entry_t in_entry,
    input  logic      grant,
    output logic      full,
    output wr_entry_t entry,
    output logic      ready
);

    logic load;

    // Ready comes only from registered state and the grant, never from in_valid.
    assign ready = reset && (!full || grant);
    assign load  = in_valid && ready && !is_reg_zero(in_entry.addr);

    always_ff @(posedge clk) begin
        if (!reset) begin
            full  <= 1'b0;
            entry <= '0;
        end else if (load) begin
            full  <= 1'b1;
            entry <= in_entry;
        end else if (grant) begin
            full  <= 1'b0;
        end
    end

endmodule

// File: rtl/grf_wr_arbiter.sv
// Round-robin arbiter sharing the GRF write port between two writeback channels.
// Optional pending-write bitmap enabled by defining GRF_WR_ARB_PENDING_EN.
module grf_wr_arbiter
    import grf_arb_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    grf_wr_arbiter_if.slave  bus
);

    logic      [N_REQ-1:0] full;
    logic      [N_REQ-1:0] grant;
    wr_entry_t             slot_entry [N_REQ];
    wr_entry_t             win_entry;
    logic                  last;

    for (genvar g = 0; g < N_REQ; g++) begin : g_slot
        wr_entry_t in_entry;

        assign in_entry = '{addr: bus.req_addr[g], data: bus.req_data[g], pc: bus.req_pc[g]};

        grf_arb_slot u_slot (
            .clk      (clk),
            .reset    (reset),
            .in_valid (bus.req_valid[g]),
            .in_entry (in_entry),
            .grant    (grant[g]),
            .full     (full[g]),
            .entry    (slot_entry[g]),
            .ready    (bus.req_ready[g])
        );
    end

    // last==1 means ch1 won most recently, so ch0 takes the next contention.
    always_comb begin
        grant = full;
        if (full[0] && full[1]) begin
            grant[0] = last;
            grant[1] = !last;
        end
    end

    assign win_entry = grant[1] ? slot_entry[1] : slot_entry[0];

    always_ff @(posedge clk) begin
        if (!reset) begin
            last          <= 1'b1;
            bus.grf_we    <= 1'b0;
            bus.grf_waddr <= '0;
            bus.grf_wdata <= '0;
            bus.grf_pc    <= '0;
        end else if (|grant) begin
            last          <= grant[1];
            bus.grf_we    <= 1'b1;
            bus.grf_waddr <= win_entry.addr;
            bus.grf_wdata <= win_entry.data;
            bus.grf_pc    <= win_entry.pc;
        end else begin
            bus.grf_we    <= 1'b0;
        end
    end

`ifdef GRF_WR_ARB_PENDING_EN
    logic [31:0] pending_c;

    always_comb begin
        pending_c = '0;
        for (int r = 1; r < 32; r++) begin
            pending_c[r] = (full[0] && slot_entry[0].addr == AW'(r))
                        || (full[1] && slot_entry[1].addr == AW'(r))
                        || (bus.grf_we && bus.grf_waddr == AW'(r));
        end
    end

    assign bus.pending = pending_c;
`else
    assign bus.pending = 32'b0;
`endif

endmodule

// File: tb/tb_grf_wr_arbiter.sv
// Self-checking bench for grf_wr_arbiter: directed vector table, corner sequences, random vs queue model.
module tb_grf_wr_arbiter;
    import grf_arb_pkg::*;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic [31:0] p0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic [31:0] p1;
    } stim_t;

    typedef struct {
        stim_t       s;
        logic        e_r0;
        logic        e_r1;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [31:0] e_pend;
    } vec_t;

    logic clk;
    logic reset;
    grf_wr_arbiter_if bus();

    grf_wr_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Reference model: each channel holds at most one queued write; output register mirrors the last grant.
    wr_entry_t   mq0[$];
    wr_entry_t   mq1[$];
    logic        m_last;
    logic        m_we;
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [31:0] m_pc;

    logic        obs_r0, obs_r1, obs_we;
    logic [4:0]  obs_waddr;
    logic [31:0] obs_wdata, obs_pc, obs_pend;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int m_winner();
        if (mq0.size() != 0 && mq1.size() != 0) return m_last ? 0 : 1;
        if (mq0.size() != 0) return 0;
        if (mq1.size() != 0) return 1;
        return -1;
    endfunction

    function automatic logic [31:0] m_pending();
        logic [31:0] p;
        p = '0;
`ifdef GRF_WR_ARB_PENDING_EN
        foreach (mq0[i]) p[mq0[i].addr] = 1'b1;
        foreach (mq1[i]) p[mq1[i].addr] = 1'b1;
        if (m_we) p[m_addr] = 1'b1;
        p[0] = 1'b0;
`endif
        return p;
    endfunction

    function automatic stim_t st(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                                 input logic [31:0] p0, input logic v1, input logic [4:0] a1,
                                 input logic [31:0] d1, input logic [31:0] p1);
        stim_t s;
        s.v0 = v0; s.a0 = a0; s.d0 = d0; s.p0 = p0;
        s.v1 = v1; s.a1 = a1; s.d1 = d1; s.p1 = p1;
        return s;
    endfunction

    function automatic vec_t vc(input stim_t s, input logic r0, input logic r1, input logic we,
                                input logic [4:0] wa, input logic [31:0] wd, input logic [31:0] pd);
        vec_t v;
        v.s = s; v.e_r0 = r0; v.e_r1 = r1; v.e_we = we;
        v.e_waddr = wa; v.e_wdata = wd; v.e_pend = pd;
        return v;
    endfunction

    // One clock cycle: drive inputs, check against the model before the edge, then advance the model.
    task automatic cyc(input logic rst_v, input stim_t s);
        int w;
        logic er0, er1;
        wr_entry_t e;
        @(negedge clk);
        reset = rst_v;
        bus.req_valid[0] = s.v0; bus.req_addr[0] = s.a0; bus.req_data[0] = s.d0; bus.req_pc[0] = s.p0;
        bus.req_valid[1] = s.v1; bus.req_addr[1] = s.a1; bus.req_data[1] = s.d1; bus.req_pc[1] = s.p1;
        #1;
        w   = m_winner();
        er0 = rst_v && (mq0.size() == 0 || w == 0);
        er1 = rst_v && (mq1.size() == 0 || w == 1);
        obs_r0 = bus.req_ready[0]; obs_r1 = bus.req_ready[1];
        obs_we = bus.grf_we; obs_waddr = bus.grf_waddr; obs_wdata = bus.grf_wdata;
        obs_pc = bus.grf_pc; obs_pend = bus.pending;
        chk("model_ready0", {31'b0, obs_r0}, {31'b0, er0});
        chk("model_ready1", {31'b0, obs_r1}, {31'b0, er1});
        chk("model_we", {31'b0, obs_we}, {31'b0, m_we});
        chk("model_waddr", {27'b0, obs_waddr}, {27'b0, m_addr});
        chk("model_wdata", obs_wdata, m_data);
        chk("model_pc", obs_pc, m_pc);
        chk("model_pending", obs_pend, m_pending());
        if (!rst_v) begin
            mq0.delete(); mq1.delete();
            m_last = 1'b1; m_we = 1'b0; m_addr = '0; m_data = '0; m_pc = '0;
        end else begin
            if (w == 0) begin
                e = mq0.pop_front();
            end else if (w == 1) begin
                e = mq1.pop_front();
            end
            if (w >= 0) begin
                m_we = 1'b1; m_addr = e.addr; m_data = e.data; m_pc = e.pc; m_last = (w == 1);
            end else begin
                m_we = 1'b0;
            end
            if (s.v0 && er0 && s.a0 != 5'd0) mq0.push_back('{addr: s.a0, data: s.d0, pc: s.p0});
            if (s.v1 && er1 && s.a1 != 5'd0) mq1.push_back('{addr: s.a1, data: s.d1, pc: s.p1});
        end
    endtask

    vec_t  tbl [11];
    stim_t idle;

    initial begin
        logic [31:0] exp_p;
        logic [4:0]  got [$];
        logic [4:0]  exp_seq [8];
        int i0, i1;

        idle = st(0, 0, 0, 0, 0, 0, 0, 0);
        tbl[0]  = vc(idle, 1, 1, 0, 0, 32'h0, 32'h0);
        tbl[1]  = vc(st(1, 5, 32'h1234, 32'h3000, 0, 0, 0, 0), 1, 1, 0, 0, 32'h0, 32'h0);
        tbl[2]  = vc(idle, 1, 1, 0, 0, 32'h0, 32'h20);
        tbl[3]  = vc(idle, 1, 1, 1, 5, 32'h1234, 32'h20);
        tbl[4]  = vc(idle, 1, 1, 0, 5, 32'h1234, 32'h0);
        tbl[5]  = vc(st(1, 0, 32'hDEAD, 32'h3004, 0, 0, 0, 0), 1, 1, 0, 5, 32'h1234, 32'h0);
        tbl[6]  = vc(idle, 1, 1, 0, 5, 32'h1234, 32'h0);
        tbl[7]  = vc(st(0, 0, 0, 0, 1, 7, 32'h77, 32'h4000), 1, 1, 0, 5, 32'h1234, 32'h0);
        tbl[8]  = vc(idle, 1, 1, 0, 5, 32'h1234, 32'h80);
        tbl[9]  = vc(idle, 1, 1, 1, 7, 32'h77, 32'h80);
        tbl[10] = vc(idle, 1, 1, 0, 7, 32'h77, 32'h0);

        reset = 1'b0;
        bus.req_valid = '0; bus.req_addr = '0; bus.req_data = '0; bus.req_pc = '0;
        mq0.delete(); mq1.delete();
        m_last = 1'b1; m_we = 1'b0; m_addr = '0; m_data = '0; m_pc = '0;
        repeat (2) @(posedge clk);

        // Directed table: single ch0 write, zero-register discard, single ch1 write.
        for (int k = 0; k < 11; k++) begin
            cyc(1'b1, tbl[k].s);
`ifdef GRF_WR_ARB_PENDING_EN
            exp_p = tbl[k].e_pend;
`else
            exp_p = 32'h0;
`endif
            chk($sformatf("tbl%0d_ready0", k), {31'b0, obs_r0}, {31'b0, tbl[k].e_r0});
            chk($sformatf("tbl%0d_ready1", k), {31'b0, obs_r1}, {31'b0, tbl[k].e_r1});
            chk($sformatf("tbl%0d_we", k), {31'b0, obs_we}, {31'b0, tbl[k].e_we});
            chk($sformatf("tbl%0d_waddr", k), {27'b0, obs_waddr}, {27'b0, tbl[k].e_waddr});
            chk($sformatf("tbl%0d_wdata", k), obs_wdata, tbl[k].e_wdata);
            chk($sformatf("tbl%0d_pending", k), obs_pend, exp_p);
            if (k == 3) chk("tbl3_pc", obs_pc, 32'h3000);
        end

        // Contention after reset: ch0 first, then strict alternation, ready toggling.
        cyc(1'b0, idle);
        exp_seq = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11, 5'd4, 5'd12};
        i0 = 0; i1 = 0;
        for (int k = 0; k < 12; k++) begin
            logic v0, v1;
            v0 = (i0 < 4); v1 = (i1 < 4);
            cyc(1'b1, st(v0, 5'(1 + i0), 32'h100 + i0, 32'h1000, v1, 5'(9 + i1), 32'h900 + i1, 32'h9000));
            if (v0 && obs_r0) i0++;
            if (v1 && obs_r1) i1++;
            if (obs_we) got.push_back(obs_waddr);
            if (k >= 1 && k <= 6) begin
                chk($sformatf("alt_ready0_c%0d", k), {31'b0, obs_r0}, {31'b0, (k % 2 == 1)});
                chk($sformatf("alt_ready1_c%0d", k), {31'b0, obs_r1}, {31'b0, (k % 2 == 0)});
            end
        end
        chk("alt_count", got.size(), 8);
        for (int k = 0; k < 8 && k < got.size(); k++)
            chk($sformatf("alt_order%0d", k), {27'b0, got[k]}, {27'b0, exp_seq[k]});

        // ch1 alone streams 8 writes back-to-back.
        for (int j = 0; j < 11; j++) begin
            cyc(1'b1, st(0, 0, 0, 0, (j < 8), 5'(16 + j), 32'hA000 + j, 32'hB000));
            if (j < 8) chk($sformatf("stream_ready1_%0d", j), {31'b0, obs_r1}, 32'd1);
            if (j >= 2 && j <= 9) begin
                chk($sformatf("stream_we_%0d", j), {31'b0, obs_we}, 32'd1);
                chk($sformatf("stream_waddr_%0d", j), {27'b0, obs_waddr}, 32'(16 + j - 2));
            end
            if (j == 10) chk("stream_we_end", {31'b0, obs_we}, 32'd0);
        end

        // Reset with both slots full, then first contention goes to ch0.
        cyc(1'b1, st(1, 3, 32'h33, 32'h5000, 1, 13, 32'hD3, 32'h6000));
        cyc(1'b0, idle);
        chk("rst_ready0", {31'b0, obs_r0}, 32'd0);
        chk("rst_ready1", {31'b0, obs_r1}, 32'd0);
        cyc(1'b1, idle);
        chk("post_rst_we", {31'b0, obs_we}, 32'd0);
        chk("post_rst_pending", obs_pend, 32'd0);
        cyc(1'b1, st(1, 4, 32'h44, 32'h5004, 1, 14, 32'hE4, 32'h6004));
        chk("post_rst_we2", {31'b0, obs_we}, 32'd0);
        cyc(1'b1, idle);
        cyc(1'b1, idle);
        chk("post_rst_first_we", {31'b0, obs_we}, 32'd1);
        chk("post_rst_first_addr", {27'b0, obs_waddr}, 32'd4);
        cyc(1'b1, idle);
        chk("post_rst_second_addr", {27'b0, obs_waddr}, 32'd14);

        // Random traffic against the model, with occasional resets.
        for (int k = 0; k < 400; k++) begin
            logic rv;
            rv = ($urandom_range(0, 49) != 0);
            cyc(rv, st(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom,
                       1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom, $urandom));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
